// File: rtl/counter_key_scheduler.sv
// -----------------------------------------------------------------------------
// counter_key_scheduler
//
// Front end for the blackjack card counter. It takes five raw push-button levels
// and turns each accepted press into exactly one single-cycle command pulse, with
// forced idle spacing between pulses.
//
// Datapath:
//   raw key -> 2-flop synchroniser -> per-key debouncer -> rising-edge event ->
//   per-key pending flag -> fixed-priority arbiter -> command FIFO -> issue FSM.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   key_large/seven/small/deck/back   raw buttons, asynchronous to clk
//   cmd_large_add/seven_add/small_add/deck_add/back
//                    registered one-cycle pulses, at most one high per cycle
//   fifo_level       number of queued commands, 0..FIFO_DEPTH
//   overflow         sticky; a press arrived while its key was still pending
//   busy             FSM not idle, FIFO non-empty or any key pending
//
// Configuration macro: KEY_REPEAT_EN
//   When defined, a held back key re-raises its pending flag every
//   REPEAT_CYCLES cycles after the press. When undefined, REPEAT_CYCLES is
//   unused and each press of back gives one command.
// -----------------------------------------------------------------------------
module counter_key_scheduler #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_large,
  input  logic                          key_seven,
  input  logic                          key_small,
  input  logic                          key_deck,
  input  logic                          key_back,
  output logic                          cmd_large_add,
  output logic                          cmd_seven_add,
  output logic                          cmd_small_add,
  output logic                          cmd_deck_add,
  output logic                          cmd_back,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);

  // Key index i carries command code i+1; a higher index has higher priority.
  localparam int NUM_KEYS = 5;
  localparam int KEY_BACK = 4;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1);

  // Elaboration-time guard against unsupported parameter values.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || GAP_CYCLES < 1 ||
      REPEAT_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("counter_key_scheduler: unsupported parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] r_sync1, r_sync2;
  logic [NUM_KEYS-1:0] r_stable;
  logic [15:0]         r_db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_db_done, w_rise, w_event;
  logic [NUM_KEYS-1:0] r_pend, w_clr;
  logic                r_overflow;
  logic                w_push;
  logic [2:0]          w_push_code;
  logic [2:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                w_full, w_empty, w_pop;
  logic [2:0]          w_head;
  state_t              r_state, w_state_nxt;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_nxt;
  logic [NUM_KEYS-1:0] r_cmd, w_cmd_nxt;

  assign w_raw = {key_back, key_deck, key_large, key_seven, key_small};

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would chain the two sync
  // flops into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A key's level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle in
  // which the synchronised input disagrees with the stable level.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_db_done[i] = (r_sync2[i] != r_stable[i]) &&
                     (r_db_cnt[i] == 16'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Only debounced rising edges generate presses.
  assign w_rise = w_db_done & r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_done[i]) begin
          r_db_cnt[i] <= '0;
          r_stable[i] <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] r_rep_cnt;
  logic             w_rep_fire;

  // The timer restarts on the press itself and after every repeat, so repeats
  // land REPEAT_CYCLES, 2*REPEAT_CYCLES, ... after the debounced press.
  assign w_rep_fire = r_stable[KEY_BACK] && (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rep_cnt <= '0;
    else if (!r_stable[KEY_BACK] || w_rise[KEY_BACK] || w_rep_fire)
      r_rep_cnt <= '0;
    else
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
  end

  assign w_event = w_rise | {w_rep_fire, {(NUM_KEYS-1){1'b0}}};
`else
  assign w_event = w_rise;
`endif

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_push      = 1'b0;
    w_push_code = '0;
    w_clr       = '0;
    if (!w_full) begin
      // Ascending scan: the last (highest-index) pending key wins.
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (r_pend[i]) begin
          w_push      = 1'b1;
          w_push_code = 3'(i + 1);
          w_clr       = '0;
          w_clr[i]    = 1'b1;
        end
      end
    end
  end

  // A press arriving while its flag is still set is dropped, even if the flag
  // is being pushed this very cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | (w_event & ~r_pend);
      if (|(w_event & r_pend)) r_overflow <= 1'b1;
    end
  end

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // NOTE: the FIFO storage has no reset; only pointers and level are reset,
  // and an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue FSM: pop on leaving IDLE, one command cycle, then GAP_CYCLES idle.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    w_cmd_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_head == 3'(i + 1)) w_cmd_nxt[i] = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_GAP;
        w_gap_nxt   = '0;
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1))
          w_state_nxt = ST_IDLE;
        else
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_cmd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_cmd     <= w_cmd_nxt;
    end
  end

  assign cmd_small_add = r_cmd[0];
  assign cmd_seven_add = r_cmd[1];
  assign cmd_large_add = r_cmd[2];
  assign cmd_deck_add  = r_cmd[3];
  assign cmd_back      = r_cmd[4];
  assign fifo_level    = r_level;
  assign overflow      = r_overflow;
  assign busy          = (r_state != ST_IDLE) || !w_empty || (|r_pend);

endmodule
